// File: rtl/change_dispense_ctrl.sv
// Change payout sequencer: pays an amount in quarters, dimes and nickels, largest first,
// one hopper-acknowledged coin at a time, and tracks the per-denomination inventory.
module change_dispense_ctrl #(
  parameter int CNT_W       = 6,
  parameter int Q_INIT      = 8,
  parameter int D_INIT      = 8,
  parameter int N_INIT      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_i,
  input  logic [7:0]       amount_i,
  input  logic             eject_ack_i,
  input  logic             refill_i,
  input  logic [2:0]       refill_coin_i,
  output logic [2:0]       eject_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [7:0]       remaining_o,
  output logic [CNT_W-1:0] q_cnt_o,
  output logic [CNT_W-1:0] d_cnt_o,
  output logic [CNT_W-1:0] n_cnt_o,
  output logic [2:0]       state_o
);

  // Handshake: eject_o is a one-cycle strobe; the hopper answers with a single-cycle
  // eject_ack_i, which is only looked at while waiting for it.

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_WAIT_ACK,
    S_DONE,
    S_ERR
  } state_e;

  localparam int TMO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0] COIN_Q = 3'b100;
  localparam logic [2:0] COIN_D = 3'b010;
  localparam logic [2:0] COIN_N = 3'b001;

  state_e           state_q, state_d;
  logic [2:0]       coin_q, coin_d;
  logic [7:0]       rem_q, rem_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] q_cnt_q, q_cnt_d;
  logic [CNT_W-1:0] d_cnt_q, d_cnt_d;
  logic [CNT_W-1:0] n_cnt_q, n_cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      coin_q  <= 3'b000;
      rem_q   <= 8'd0;
      tmo_q   <= '0;
      q_cnt_q <= CNT_W'(Q_INIT);
      d_cnt_q <= CNT_W'(D_INIT);
      n_cnt_q <= CNT_W'(N_INIT);
    end else begin
      state_q <= state_d;
      coin_q  <= coin_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      q_cnt_q <= q_cnt_d;
      d_cnt_q <= d_cnt_d;
      n_cnt_q <= n_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    coin_d  = coin_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    q_cnt_d = q_cnt_q;
    d_cnt_d = d_cnt_q;
    n_cnt_d = n_cnt_q;
    eject_o = 3'b000;
    done_o  = 1'b0;
    error_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A refill landing on the same edge as a request is still counted.
        if (refill_i) begin
          case (refill_coin_i)
            COIN_Q:  if (q_cnt_q != CNT_MAX) q_cnt_d = q_cnt_q + CNT_ONE;
            COIN_D:  if (d_cnt_q != CNT_MAX) d_cnt_d = d_cnt_q + CNT_ONE;
            COIN_N:  if (n_cnt_q != CNT_MAX) n_cnt_d = n_cnt_q + CNT_ONE;
            default: ;
          endcase
        end
        if (req_i) begin
          rem_d   = amount_i;
          state_d = ((amount_i % 8'd5) == 8'd0) ? S_SELECT : S_ERR;
        end
      end
      S_SELECT: begin
        if (rem_q == 8'd0) begin
          state_d = S_DONE;
        end else if (rem_q >= 8'd25 && q_cnt_q != '0) begin
          coin_d  = COIN_Q;
          state_d = S_EJECT;
        end else if (rem_q >= 8'd10 && d_cnt_q != '0) begin
          coin_d  = COIN_D;
          state_d = S_EJECT;
        end else if (rem_q >= 8'd5 && n_cnt_q != '0) begin
          coin_d  = COIN_N;
          state_d = S_EJECT;
        end else begin
          state_d = S_ERR;
        end
      end
      S_EJECT: begin
        eject_o = coin_q;
        tmo_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // An ack on the final allowed cycle still counts as a paid coin.
        if (eject_ack_i) begin
          case (coin_q)
            COIN_Q: begin
              q_cnt_d = q_cnt_q - CNT_ONE;
              rem_d   = rem_q - 8'd25;
            end
            COIN_D: begin
              d_cnt_d = d_cnt_q - CNT_ONE;
              rem_d   = rem_q - 8'd10;
            end
            default: begin
              n_cnt_d = n_cnt_q - CNT_ONE;
              rem_d   = rem_q - 8'd5;
            end
          endcase
          state_d = S_SELECT;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        error_o = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign remaining_o = rem_q;
  assign q_cnt_o     = q_cnt_q;
  assign d_cnt_o     = d_cnt_q;
  assign n_cnt_o     = n_cnt_q;
  assign state_o     = state_q;

endmodule
